// File: rtl/fault_campaign_seq_if.sv
// Host, DUT-wrapper and result-stream signals of the fault campaign sequencer.
// master = sequencer side, slave = host/DUT-wrapper side.
interface fault_campaign_seq_if #(
  parameter int DATA_W  = 128,
  parameter int FID_W   = 16,
  parameter int NUM_VEC = 3
);
  localparam int FV_W = $clog2(NUM_VEC + 1);

  logic              start;
  logic [FID_W-1:0]  batch_start;
  logic [FID_W-1:0]  batch_end;
  logic              busy;
  logic              done;
  logic [FID_W-1:0]  fault_id;
  logic              fault_en;
  logic [DATA_W-1:0] vec_a;
  logic [DATA_W-1:0] vec_b;
  logic [DATA_W-1:0] dut_sum;
  logic              dut_cout;
  // res_valid/res_ready: a result transfers on a rising clk edge where both are
  // high. While res_valid is high and res_ready low, res_* stay stable; res_valid
  // never depends combinationally on res_ready and drops only after a transfer.
  logic              res_valid;
  logic              res_ready;
  logic [FID_W-1:0]  res_fid;
  logic              res_detected;
  logic [FV_W-1:0]   res_first_vec;
  logic [FID_W-1:0]  det_count;

  modport master (
    input  start, batch_start, batch_end, dut_sum, dut_cout, res_ready,
    output busy, done, fault_id, fault_en, vec_a, vec_b,
           res_valid, res_fid, res_detected, res_first_vec, det_count
  );

  modport slave (
    output start, batch_start, batch_end, dut_sum, dut_cout, res_ready,
    input  busy, done, fault_id, fault_en, vec_a, vec_b,
           res_valid, res_fid, res_detected, res_first_vec, det_count
  );
endinterface

// File: rtl/fault_campaign_seq.sv
// Fault-injection campaign sequencer: golden pass, then one pass per fault ID.
// Optional macro FCS_EARLY_ABORT_EN ends a fault pass at its first mismatch.
module fault_campaign_seq #(
  parameter int          DATA_W     = 128,
  parameter int          FID_W      = 16,
  parameter int          NUM_VEC    = 3,
  parameter int          SETTLE_CYC = 1,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rst,
  fault_campaign_seq_if.master bus,
  output logic [2:0]           dbg_state
);
  localparam int FV_W = $clog2(NUM_VEC + 1);
  localparam int K_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int S_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, G_APPLY, G_WAIT, F_APPLY, F_WAIT, EMIT, FIN
  } state_t;

  state_t            state;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    ld_idx;
  logic [S_W-1:0]    cnt;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_base;
  logic [31:0]       lfsr_load;
  logic [DATA_W:0]   golden [NUM_VEC];
  logic [FID_W-1:0]  b_start;
  logic [FID_W-1:0]  b_end;
  logic              det_q;
  logic [FV_W-1:0]   fv_q;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;
  logic [DATA_W:0]   sample;
  logic              wait_last;
  logic              last_k;
  logic              mism;
  logic              det_nxt;
  logic              abort;
  logic              last_fid;
  logic [FV_W-1:0]   fv_nxt;

  // Galois LFSR for x^32 + x^22 + x^2 + x + 1, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [31:0] s);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = s[i % 32];
    return r;
  endfunction

  assign dbg_state = 3'(state);

  // Vectors are registered on the transition into an APPLY state, so the DUT sees
  // vector k throughout APPLY and all its settle cycles. For k >= 3, a is the
  // LFSR state and b its successor; index 0 always restarts from the seed.
  always_comb begin
    wait_last = (int'(cnt) == SETTLE_CYC - 1);
    last_k    = (int'(k) == NUM_VEC - 1);
    ld_idx    = ((state == G_WAIT || state == F_WAIT) && !last_k) ? k + K_W'(1) : '0;
    lfsr_base = (ld_idx == '0) ? LFSR_SEED : lfsr;
    lfsr_load = lfsr_base;
    nxt_a     = '0;
    nxt_b     = '0;
    case (int'(ld_idx))
      0: begin
        nxt_a = '1;
        nxt_b = DATA_W'(1);
      end
      1: begin
        nxt_a = DATA_W'(1);
        nxt_b = '1;
      end
      2: begin
        nxt_a = '0;
        nxt_b = '0;
      end
      default: begin
        nxt_a     = replicate(lfsr_base);
        nxt_b     = replicate(lfsr_step(lfsr_base));
        lfsr_load = lfsr_step(lfsr_base);
      end
    endcase

    sample  = {bus.dut_cout, bus.dut_sum};
    mism    = (sample != golden[k]);
    det_nxt = det_q | mism;
    fv_nxt  = (mism && !det_q) ? FV_W'(k) : fv_q;
`ifdef FCS_EARLY_ABORT_EN
    abort   = mism;
`else
    abort   = 1'b0;
`endif
    // Widened by one bit so the last usable ID never wraps into a false match.
    last_fid = (({1'b0, bus.fault_id} + (FID_W + 1)'(1)) == {1'b0, b_end});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      k                 <= '0;
      cnt               <= '0;
      lfsr              <= LFSR_SEED;
      b_start           <= '0;
      b_end             <= '0;
      det_q             <= 1'b0;
      fv_q              <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.fault_id      <= '0;
      bus.fault_en      <= 1'b0;
      bus.vec_a         <= '0;
      bus.vec_b         <= '0;
      bus.res_valid     <= 1'b0;
      bus.res_fid       <= '0;
      bus.res_detected  <= 1'b0;
      bus.res_first_vec <= '0;
      bus.det_count     <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            b_start       <= bus.batch_start;
            b_end         <= bus.batch_end;
            bus.busy      <= 1'b1;
            bus.det_count <= '0;
            bus.fault_en  <= 1'b0;
            k             <= '0;
            bus.vec_a     <= nxt_a;
            bus.vec_b     <= nxt_b;
            lfsr          <= lfsr_load;
            state         <= G_APPLY;
          end
        end

        G_APPLY: begin
          cnt   <= '0;
          state <= G_WAIT;
        end

        G_WAIT: begin
          if (wait_last) begin
            golden[k] <= sample;
            if (!last_k) begin
              k         <= k + K_W'(1);
              bus.vec_a <= nxt_a;
              bus.vec_b <= nxt_b;
              lfsr      <= lfsr_load;
              state     <= G_APPLY;
            end else begin
              k <= '0;
              if (b_start >= b_end) begin
                state <= FIN;
              end else begin
                bus.fault_id <= b_start;
                bus.fault_en <= 1'b1;
                det_q        <= 1'b0;
                fv_q         <= FV_W'(NUM_VEC);
                bus.vec_a    <= nxt_a;
                bus.vec_b    <= nxt_b;
                lfsr         <= lfsr_load;
                state        <= F_APPLY;
              end
            end
          end else begin
            cnt <= cnt + S_W'(1);
          end
        end

        F_APPLY: begin
          cnt   <= '0;
          state <= F_WAIT;
        end

        F_WAIT: begin
          if (wait_last) begin
            det_q <= det_nxt;
            fv_q  <= fv_nxt;
            if (last_k || abort) begin
              bus.res_valid     <= 1'b1;
              bus.res_fid       <= bus.fault_id;
              bus.res_detected  <= det_nxt;
              bus.res_first_vec <= fv_nxt;
              state             <= EMIT;
            end else begin
              k         <= k + K_W'(1);
              bus.vec_a <= nxt_a;
              bus.vec_b <= nxt_b;
              lfsr      <= lfsr_load;
              state     <= F_APPLY;
            end
          end else begin
            cnt <= cnt + S_W'(1);
          end
        end

        EMIT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (bus.res_detected && (bus.det_count != '1))
              bus.det_count <= bus.det_count + FID_W'(1);
            if (last_fid) begin
              state <= FIN;
            end else begin
              bus.fault_id <= bus.fault_id + FID_W'(1);
              k            <= '0;
              det_q        <= 1'b0;
              fv_q         <= FV_W'(NUM_VEC);
              bus.vec_a    <= nxt_a;
              bus.vec_b    <= nxt_b;
              lfsr         <= lfsr_load;
              state        <= F_APPLY;
            end
          end
        end

        FIN: begin
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          bus.fault_en <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fault_campaign_seq.md
Name: fault_campaign_seq

Overview:
- Synthesizable fault-injection campaign sequencer for gate-level adder netlists that already contain fault-injection MUXes selected by a fault-ID input.
- Runs one golden (fault-free) pass, then iterates fault IDs over [batch_start, batch_end). For each ID it applies a parametrised vector set, compares the DUT sum and carry against the golden values, and streams out one result per fault.
- Sits between the campaign host interface and the DUT wrapper.
- Replaces the fixed 3-vector, non-synthesizable batch loop with a width-, depth- and vector-count-generic hardware engine.

Parameters:
- DATA_W, 128: adder operand/sum width.
- FID_W, 16: fault ID width. ID 0 is not reserved; fault_en gates injection.
- NUM_VEC, 3: vectors per pass; must be ≥ 1.
- SETTLE_CYC, 1: wait cycles after a vector is applied, before sampling; must be ≥ 1.
- LFSR_SEED, 32'hACE1_2468: seed for vectors with index ≥ 3; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  campaign start pulse; accepted only in IDLE
- batch_start  in  FID_W  first fault ID (inclusive); sampled on start
- batch_end  in  FID_W  last fault ID (exclusive); sampled on start
- busy  out  1  high from start acceptance until DONE
- done  out  1  one-cycle pulse at campaign end
- fault_id  out  FID_W  drives DUT fault select
- fault_en  out  1  0 during golden pass, 1 during fault passes
- vec_a  out  DATA_W  DUT operand a
- vec_b  out  DATA_W  DUT operand b
- dut_sum  in  DATA_W  DUT sum
- dut_cout  in  1  DUT carry out
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_fid  out  FID_W  fault ID of result
- res_detected  out  1  any vector mismatched
- res_first_vec  out  $clog2(NUM_VEC+1)  index of first mismatching vector; NUM_VEC if undetected
- det_count  out  FID_W  detected-fault count, saturating at all-ones

Behaviour:
- Reset values: busy=0, done=0, fault_id=0, fault_en=0, vec_a=0, vec_b=0, res_valid=0, res_fid=0, res_detected=0, res_first_vec=0, det_count=0. FSM goes to IDLE. Reset mid-campaign aborts immediately; the golden store is treated as invalid.
- Vector set, index k:
  - k=0: a=all-ones, b=1.
  - k=1: a=1, b=all-ones.
  - k=2: a=0, b=0.
  - k≥3: a and b come from a 32-bit Galois LFSR (taps 32,22,2,1) replicated across DATA_W; a takes the current state, b the next state.
  - The LFSR reloads LFSR_SEED at the start of every pass, so every pass applies identical vectors.
- FSM states: IDLE, G_APPLY, G_WAIT, F_APPLY, F_WAIT, EMIT, FIN.
  - IDLE: on start, latch bounds, set busy=1, det_count=0, go to G_APPLY.
  - G_APPLY: 1 cycle; drive vector k with fault_en=0.
  - G_WAIT: SETTLE_CYC cycles. On the last cycle, store {dut_cout, dut_sum} into golden[k]. Then go to G_APPLY for k+1, or after the last k go to FIN if batch_start ≥ batch_end, else to F_APPLY with fault_id=batch_start.
  - F_APPLY / F_WAIT: same timing as the golden pass with fault_en=1. On the last wait cycle, compare against golden[k]. The first mismatch sets the detected flag and records k. After the last vector, go to EMIT.
  - EMIT: res_valid=1 with res_* held stable until res_ready. On handshake: det_count increments if detected (saturating). If fault_id+1 == batch_end, go to FIN; else increment fault_id and go to F_APPLY. fault_id must not wrap: batch_end=2^FID_W is not expressible, and the last usable ID is 2^FID_W−2.
  - FIN: done=1 for one cycle, busy=0, fault_en=0, then IDLE.
- Latency:
  - Per pass: NUM_VEC×(1+SETTLE_CYC) cycles, plus ≥1 EMIT cycle.
  - First result appears 2×NUM_VEC×(1+SETTLE_CYC) cycles after start, with res_ready tied high.
- Other rules:
  - start while busy is ignored.
  - res_valid may be held indefinitely; the FSM stalls in EMIT and vec_a/vec_b hold the last vector.
  - fault_id changes only in the EMIT→F_APPLY transition, so injection never changes mid-vector.
  - Golden store is NUM_VEC×(DATA_W+1) registers.

Optional Feature:
- Macro: FCS_EARLY_ABORT_EN.
- Defined: on the first mismatch in a fault pass, skip the remaining vectors and go directly to EMIT. res_first_vec is unchanged in meaning.
- Undefined: all NUM_VEC vectors are always applied; pass length is constant.

Test Plan:
- Mock DUT (correct adder; ID 5 = sum[0] stuck-1), NUM_VEC=3, range [5,6) → one result: fid=5, detected=1, first_vec=0 (golden sum[0]=0). det_count=1, done pulses.
- ID 7 = cout stuck-0, range [7,8) → detected=1, first_vec=0 (golden cout=1).
- ID 9 = sum[0] stuck-0, NUM_VEC=3 → detected=0, first_vec=3. Rerun with NUM_VEC=8 → detection occurs at some LFSR vector index ≥3.
- batch_start=10, batch_end=10 → golden pass only, no res_valid, done after 3×(1+SETTLE_CYC)+1 cycles.
- Range [0,4), res_ready low for 20 cycles in each EMIT → res_* stable during the stall, fault_id unchanged, 4 results in order 0..3.
- rst asserted mid F_WAIT → next cycle all outputs at reset values. A subsequent start reruns the golden pass and produces correct results.
